exa_crosb_outp_arb: RTL and testbench

- Per-output-port arbiter for the crossbar. Shares one output port between N input ports using round-robin.
- Holds the grant for the whole packet, from head beat through tail beat.
- Drives a registered one-hot grant and a binary mux select. The select is derived from the grant by the crossbar one-hot-to-binary encoder.
- One instance per crossbar output port; sits beside the output data mux.

---
 rtl/exa_crosb_outp_arb_pkg.sv | 36 +++
 rtl/exa_crosb_outp_arb_if.sv | 28 ++
 rtl/exa_crosb_outp_arb_1h_to_b.sv | 20 ++
 rtl/exa_crosb_outp_arb.sv | 98 +++++++++
 tb/tb_exa_crosb_outp_arb.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/exa_crosb_outp_arb_pkg.sv
// Shared crossbar definitions used by the output-port arbiter.
//   XBAR_MAX_PORTS : widest input fan-in any crossbar port supports
//   arb_state_e    : arbiter state values (IDLE / LOCKED)
//   rr_pick()      : round-robin winner search, returns a one-hot vector
package exa_crosb_outp_arb_pkg;

    localparam int XBAR_MAX_PORTS = 16;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // First set bit of req searching upward from ptr+1, wrapping modulo n.
    // Bits at or above n are ignored; returns zero when nothing requests.
    function automatic logic [XBAR_MAX_PORTS-1:0] rr_pick(
        input logic [XBAR_MAX_PORTS-1:0] req,
        input logic [3:0]                ptr,
        input int                        n
    );
        logic [XBAR_MAX_PORTS-1:0] win;
        logic                      found;
        logic [3:0]                idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= XBAR_MAX_PORTS; k++) begin
            idx = 4'((int'(ptr) + k) % n);
            if (k <= n && !found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/exa_crosb_outp_arb_if.sv
// Handshake bundle between the N input ports / downstream port and one
// output-port arbiter.
//   master : request side (drives i_valid, i_tail, i_out_ready)
//   slave  : arbiter side (drives o_grant, o_sel, o_valid, o_busy, o_wdog)
interface exa_crosb_outp_arb_if #(
    parameter int N_INPUTS = 4
);
    localparam int SEL_W = $clog2(N_INPUTS);

    logic [N_INPUTS-1:0] i_valid;
    logic [N_INPUTS-1:0] i_tail;
    logic                i_out_ready;
    logic [N_INPUTS-1:0] o_grant;
    logic [SEL_W-1:0]    o_sel;
    logic                o_valid;
    logic                o_busy;
    logic                o_wdog;

    modport master (
        output i_valid, i_tail, i_out_ready,
        input  o_grant, o_sel, o_valid, o_busy, o_wdog
    );

    modport slave (
        input  i_valid, i_tail, i_out_ready,
        output o_grant, o_sel, o_valid, o_busy, o_wdog
    );
endinterface

// File: rtl/exa_crosb_outp_arb_1h_to_b.sv
// Crossbar one-hot to binary encoder (ss_1h_to_b).
//   i_onehot : one-hot (or all-zero) vector
//   o_bin    : index of the set bit; 0 when the input is all-zero
module ss_1h_to_b #(
    parameter  int input_width = 4,
    localparam int OUT_W       = $clog2(input_width)
) (
    input  logic [input_width-1:0] i_onehot,
    output logic [OUT_W-1:0]       o_bin
);

    // OR of the indices of every set bit; exact for a one-hot input.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < input_width; i++) begin
            if (i_onehot[i]) o_bin = o_bin | OUT_W'(i);
        end
    end

endmodule

// File: rtl/exa_crosb_outp_arb.sv
// Per-output-port round-robin arbiter for the crossbar. Locks the output to
// one input from head beat through tail beat, with an optional packet-length
// watchdog that forces a release after MAX_BEATS transfers.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : i_valid/i_tail per input, i_out_ready from downstream;
//                 o_grant (registered one-hot), o_sel (binary), o_valid,
//                 o_busy (LOCKED), o_wdog (watchdog release pulse)
module exa_crosb_outp_arb
    import exa_crosb_outp_arb_pkg::*;
#(
    parameter  int N_INPUTS  = 4,
    parameter  int MAX_BEATS = 64,
    localparam int SEL_W     = $clog2(N_INPUTS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    exa_crosb_outp_arb_if.slave   bus
);

    localparam int            CNT_W     = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [0:0]    ST_IDLE   = ARB_IDLE;
    localparam logic [0:0]    ST_LOCKED = ARB_LOCKED;

    logic [0:0]          state_q, state_d;
    logic [N_INPUTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [SEL_W-1:0]          sel;
    logic                      locked, valid, xfer, tail, wd_hit;
    logic [XBAR_MAX_PORTS-1:0] pick_wide;
    logic                      unused_pick;

    ss_1h_to_b #(.input_width(N_INPUTS)) u_enc (
        .i_onehot (grant_q),
        .o_bin    (sel)
    );

    assign locked = (state_q == ST_LOCKED);
    assign valid  = locked & bus.i_valid[sel];
    assign xfer   = valid & bus.i_out_ready;
    assign tail   = bus.i_tail[sel];

    // The transfer that would make the count reach MAX_BEATS without a
    // tail is the one that forces the release.
    generate
        if (MAX_BEATS > 0) begin : g_wdog
            assign wd_hit = xfer & ~tail & (cnt_q == CNT_W'(MAX_BEATS - 1));
        end else begin : g_no_wdog
            assign wd_hit = 1'b0;
        end
    endgenerate

    assign pick_wide   = rr_pick(XBAR_MAX_PORTS'(bus.i_valid), 4'(ptr_q), N_INPUTS);
    assign unused_pick = ^pick_wide;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!locked) begin
            if (|bus.i_valid) begin
                grant_d = pick_wide[N_INPUTS-1:0];
                state_d = ST_LOCKED;
            end
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
            if (tail | wd_hit) begin
                ptr_d   = sel;
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= SEL_W'(N_INPUTS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_grant = grant_q;
    assign bus.o_sel   = sel;
    assign bus.o_valid = valid;
    assign bus.o_busy  = locked;
    assign bus.o_wdog  = wd_hit;

endmodule

// File: tb/tb_exa_crosb_outp_arb.sv
// Bench for exa_crosb_outp_arb: directed scenarios plus random traffic,
// every cycle compared against a packet-level reference model.
module tb_exa_crosb_outp_arb;

    localparam int N    = 4;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    exa_crosb_outp_arb_if #(.N_INPUTS(N)) bus ();

    exa_crosb_outp_arb #(.N_INPUTS(N), .MAX_BEATS(MAXB)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owning input (-1 when idle), last winner, beats moved.
    int m_own, m_ptr, m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_own = -1;
        m_ptr = N - 1;
        m_cnt = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] t, input logic r);
        logic [N-1:0] eg;
        logic         ev, xf, ewd, found;
        int           idx;
        @(posedge clk); #1;
        bus.i_valid     = v;
        bus.i_tail      = t;
        bus.i_out_ready = r;
        @(negedge clk);
        eg  = '0;
        ev  = 1'b0;
        ewd = 1'b0;
        if (m_own >= 0) begin
            eg[m_own] = 1'b1;
            ev        = v[m_own];
        end
        xf = ev && r;
        if (xf && !t[m_own] && (m_cnt + 1 == MAXB)) ewd = 1'b1;
        chk("grant", 32'(bus.o_grant), 32'(eg));
        chk("sel",   32'(bus.o_sel),   (m_own < 0) ? 32'd0 : 32'(m_own));
        chk("valid", 32'(bus.o_valid), 32'(ev));
        chk("busy",  32'(bus.o_busy),  32'(m_own >= 0));
        chk("wdog",  32'(bus.o_wdog),  32'(ewd));
        if (m_own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && v[idx]) begin
                    m_own = idx;
                    found = 1'b1;
                end
            end
        end else if (xf) begin
            m_cnt++;
            if (t[m_own] || m_cnt == MAXB) begin
                m_ptr = m_own;
                m_own = -1;
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn          = 1'b0;
        bus.i_valid     = '0;
        bus.i_tail      = '0;
        bus.i_out_ready = 1'b0;
        m_reset();
        #3;
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_sel",   32'(bus.o_sel),   32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_busy",  32'(bus.o_busy),  32'd0);
        chk("rst_wdog",  32'(bus.o_wdog),  32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single requester, 3-beat packet on input 2.
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("single_idle", 32'(bus.o_grant), 32'd0);
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("single_grant", 32'(bus.o_grant), 32'b0100);
        chk("single_sel",   32'(bus.o_sel),   32'd2);
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0100, 4'b0100, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("single_release", 32'(bus.o_grant), 32'd0);
        // Pointer now at 2: with everyone requesting, input 3 wins.
        cyc(4'b1111, 4'b1111, 1'b1);
        cyc(4'b1111, 4'b1111, 1'b1);
        chk("ptr_after_2", 32'(bus.o_grant), 32'b1000);

        // Fairness: single-beat packets, one idle cycle between grants.
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1111, 4'b1111, 1'b1);
            chk("rr_gap", 32'(bus.o_grant), 32'd0);
            cyc(4'b1111, 4'b1111, 1'b1);
            chk("rr_order", 32'(bus.o_grant), 32'(1 << (k % 4)));
        end

        // Lock hold: input 1 stalls, input 0 waits for its tail.
        cyc(4'b0010, 4'b0000, 1'b1);
        cyc(4'b0011, 4'b0000, 1'b1);
        chk("hold_grant", 32'(bus.o_grant), 32'b0010);
        for (int k = 0; k < 2; k++) begin
            cyc(4'b0001, 4'b0000, 1'b1);
            chk("hold_stall_grant", 32'(bus.o_grant), 32'b0010);
            chk("hold_stall_valid", 32'(bus.o_valid), 32'd0);
        end
        cyc(4'b0011, 4'b0010, 1'b1);
        chk("hold_tail", 32'(bus.o_grant), 32'b0010);
        cyc(4'b0001, 4'b0001, 1'b1);
        chk("hold_gap", 32'(bus.o_grant), 32'd0);
        cyc(4'b0001, 4'b0001, 1'b1);
        chk("hold_next", 32'(bus.o_grant), 32'b0001);

        // Backpressure on the tail beat of a 4-beat packet from input 3.
        cyc(4'b1000, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) cyc(4'b1000, 4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(4'b1000, 4'b1000, 1'b0);
            chk("bp_hold", 32'(bus.o_grant), 32'b1000);
            chk("bp_busy", 32'(bus.o_busy),  32'd1);
        end
        cyc(4'b1000, 4'b1000, 1'b1);
        chk("bp_tail_wdog", 32'(bus.o_wdog), 32'd0);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("bp_release", 32'(bus.o_grant), 32'd0);

        // Watchdog: 6-beat packet from input 2, tail only on beat 6.
        cyc(4'b0100, 4'b0000, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0100, 4'b0000, 1'b1);
            chk("wd_quiet", 32'(bus.o_wdog), 32'd0);
        end
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("wd_fire",       32'(bus.o_wdog),  32'd1);
        chk("wd_fire_grant", 32'(bus.o_grant), 32'b0100);
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("wd_dropped", 32'(bus.o_grant), 32'd0);
        chk("wd_pulse",   32'(bus.o_wdog),  32'd0);
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("wd_rearb", 32'(bus.o_grant), 32'b0100);
        cyc(4'b0100, 4'b0100, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1);
        chk("wd_done", 32'(bus.o_grant), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cyc(N'($urandom), N'($urandom & $urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while locked mid-packet.
        for (int k = 0; k < 3; k++) cyc(4'b1111, 4'b0000, 1'b1);
        chk("ar_locked", 32'(bus.o_busy), 32'd1);
        #2;
        resetn          = 1'b0;
        bus.i_valid     = '0;
        bus.i_tail      = '0;
        bus.i_out_ready = 1'b0;
        #1;
        chk("ar_grant", 32'(bus.o_grant), 32'd0);
        chk("ar_busy",  32'(bus.o_busy),  32'd0);
        chk("ar_valid", 32'(bus.o_valid), 32'd0);
        m_reset();
        @(posedge clk); #1;
        @(negedge clk);
        resetn = 1'b1;
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("ar_idle", 32'(bus.o_grant), 32'd0);
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("ar_first_tie", 32'(bus.o_grant), 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
